// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO,       |
// | with busy/stall handshake for MFHI/MFLO.            Revision: 1.0        |
// +--------------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             read_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] wrk_q, wrk_d;     // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opd_q, opd_d;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] aorig_q, aorig_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             unused_bits;

  assign signed_op = op[0] & ~op[2];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign mul_sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opd_q} : '0);
  assign div_sh   = {acc_q, wrk_q[WIDTH-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, opd_q};
  assign div_ge   = ~div_diff[WIDTH+1];

  assign prod     = {acc_q, wrk_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -wrk_q : wrk_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  // Top bits are provably zero whenever they would be kept.
  assign unused_bits = ^{div_diff[WIDTH], div_sh[WIDTH]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wrk_d     = wrk_q;
    opd_d     = opd_q;
    aorig_d   = aorig_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op[2] == 1'b0) begin
            acc_d     = '0;
            wrk_d     = op[1] ? a_mag : b_mag;
            opd_d     = op[1] ? b_mag : a_mag;
            aorig_d   = a;
            is_div_d  = op[1];
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_d      = (b == '0);
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = S_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
          wrk_d = {wrk_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          if (dz_q) begin
            lo_d = '1;
            hi_d = aorig_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      wrk_q     <= '0;
      opd_q     <= '0;
      aorig_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wrk_q     <= wrk_d;
      opd_q     <= opd_d;
      aorig_q   <= aorig_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = read_req & busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
`default_nettype wire
